conv_col_writer: RTL



---
 rtl/conv_col_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/conv_col_writer.sv
// Write-back stage for the convolution array: buffers output columns in a
// 2-entry FIFO and writes each one to feature-map memory as 256-bit words.
module conv_col_writer #(
    parameter int DATA_WIDTH    = 16,
    parameter int OUT_SIZE      = 24,
    parameter int LANES         = 16,
    parameter int WORDS_PER_COL = 2,
    parameter int COL_OFFSET    = 1,
    parameter int BASE_ADDR     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        col_valid,
    input  logic [5:0]                  col_num,
    input  logic [DATA_WIDTH-1:0]       col_data [OUT_SIZE],
    input  logic                        mem_ready,
    output logic                        mem_we,
    output logic [11:0]                 mem_addr,
    output logic [LANES*DATA_WIDTH-1:0] mem_wdata,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int IDX_W  = $clog2(OUT_SIZE);
    localparam int HALF_W = (WORDS_PER_COL > 1) ? $clog2(WORDS_PER_COL) : 1;
    localparam int PAD_N  = WORDS_PER_COL * LANES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_r;
    logic                    rd_ptr_r;
    logic                    wr_ptr_r;
    logic [1:0]              count_r;
    logic [HALF_W-1:0]       half_r;
    logic                    overflow_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [2][OUT_SIZE];
    logic [IDX_W-1:0]        fifo_idx_r  [2];

    logic [5:0]              col_idx_s;
    logic                    idx_ok_s;
    logic                    in_run_s;
    logic                    fifo_empty_s;
    logic                    fifo_full_s;
    logic                    accept_s;
    logic                    last_half_s;
    logic                    pop_s;
    logic                    final_s;
    logic                    push_s;
    logic                    drop_s;
    logic [DATA_WIDTH-1:0]   head_pad_s [PAD_N];
    logic [LANES*DATA_WIDTH-1:0] word_s;
    logic [11:0]             addr_s;

    // FIFO handshake and column-acceptance decisions for this cycle
    always_comb begin
        col_idx_s    = col_num - 6'(COL_OFFSET);
        idx_ok_s     = col_idx_s < 6'(OUT_SIZE);
        in_run_s     = state_r == RUN;
        fifo_empty_s = count_r == 2'd0;
        fifo_full_s  = count_r == 2'd2;
        accept_s     = in_run_s && !fifo_empty_s && mem_ready;
        last_half_s  = half_r == HALF_W'(WORDS_PER_COL - 1);
        pop_s        = accept_s && last_half_s;
        final_s      = pop_s && (fifo_idx_r[rd_ptr_r] == IDX_W'(OUT_SIZE - 1));
        // A full FIFO still takes a column when the head leaves this cycle
        push_s       = in_run_s && !start && col_valid && idx_ok_s && (!fifo_full_s || pop_s);
        drop_s       = in_run_s && !start && col_valid && !(idx_ok_s && (!fifo_full_s || pop_s));
    end

    // Word assembly: head column zero-padded to whole words, lane select by half
    always_comb begin
        for (int e = 0; e < PAD_N; e++) begin
            head_pad_s[e] = '0;
        end
        for (int e = 0; e < OUT_SIZE; e++) begin
            head_pad_s[e] = fifo_data_r[rd_ptr_r][e];
        end
        word_s = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int h = 0; h < WORDS_PER_COL; h++) begin
                word_s[j*DATA_WIDTH +: DATA_WIDTH] = word_s[j*DATA_WIDTH +: DATA_WIDTH] |
                    ((half_r == HALF_W'(h)) ? head_pad_s[h*LANES+j] : {DATA_WIDTH{1'b0}});
            end
        end
        addr_s = 12'(BASE_ADDR + int'(fifo_idx_r[rd_ptr_r]) * WORDS_PER_COL + int'(half_r));
    end

    // Memory request outputs, parked at reset values when nothing is pending
    always_comb begin
        mem_we = in_run_s && !fifo_empty_s;
        if (mem_we) begin
            mem_wdata = word_s;
            mem_addr  = addr_s;
        end else begin
            mem_wdata = '0;
            mem_addr  = 12'(BASE_ADDR);
        end
    end

    // Control FSM, FIFO pointers, half counter and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            half_r     <= '0;
            overflow_r <= 1'b0;
        end else if (start) begin
            state_r    <= RUN;
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= 2'd0;
            half_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: state_r <= IDLE;
                RUN: begin
                    if (accept_s) begin
                        half_r <= last_half_s ? '0 : half_r + HALF_W'(1);
                    end
                    if (pop_s) begin
                        rd_ptr_r <= ~rd_ptr_r;
                    end
                    if (push_s) begin
                        wr_ptr_r <= ~wr_ptr_r;
                    end
                    count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
                    if (drop_s) begin
                        overflow_r <= 1'b1;
                    end
                    if (final_s) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // Column storage; a slot's contents only matter once it is counted valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= col_data;
            fifo_idx_r[wr_ptr_r]  <= IDX_W'(col_idx_s);
        end
    end

    assign busy     = state_r == RUN;
    assign done     = state_r == DONE;
    assign overflow = overflow_r;

endmodule
